// File: rtl/audio_i2s_rx_if.sv
// Output stream interface of the I2S receiver: one stereo frame per 32-bit beat.
//   tvalid/tdata/tstrb/tdest/tlast : driven by the receiver (master)
//   tready                         : driven by the downstream sink (slave)
interface audio_i2s_rx_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [3:0]  tdest;
    logic        tlast;

    modport master (output tvalid, tdata, tstrb, tdest, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tdest, tlast, output tready);
endinterface

// File: rtl/audio_i2s_rx.sv
// I2S receiver: synchronizes SCK/WS/SD into clk_i, deserializes left/right
// samples MSB first and emits each complete stereo frame as one stream beat.
// Ports:
//   clk_i, rst_i            system clock, synchronous active-high reset
//   i2s_sck_i/ws_i/sdata_i  raw I2S inputs, asynchronous to clk_i
//   outport                 stream master: tdata = {left, right}, left-justified
//   overflow_o              1-cycle pulse when a completed frame is dropped
//   frame_err_o             1-cycle pulse when a channel ends short of SAMPLE_W bits
module audio_i2s_rx #(
    parameter int unsigned SAMPLE_W       = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FRAMES_PER_PKT = 1,
    parameter logic [3:0]  TDEST          = 4'h0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sdata_i,
    audio_i2s_rx_if.master        outport,
    output logic                  overflow_o,
    output logic                  frame_err_o
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_W + 1);
    localparam int unsigned PKT_W = (FRAMES_PER_PKT > 1) ? $clog2(FRAMES_PER_PKT) : 1;
    localparam int unsigned PAD_W = 16 - SAMPLE_W;

    typedef enum logic [1:0] {ST_ALIGN, ST_LEFT, ST_RIGHT} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
    logic                   sck_dly_q, sck_dly_d;
    logic                   rise_q, rise_d;
    logic                   ws_smp_q, ws_smp_d;
    logic                   sd_smp_q, sd_smp_d;
    logic                   ws_last_q, ws_last_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0]    shift_q, shift_d;
    logic [SAMPLE_W-1:0]    left_q, left_d;
    state_t                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [31:0]            data_q, data_d;
    logic [3:0]             strb_q, strb_d;
    logic                   last_q, last_d;
    logic [PKT_W-1:0]       pkt_cnt_q, pkt_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   err_q, err_d;
    logic                   ws_chg;
    logic                   chan_full;
    logic                   frame_done;

    // Synchronizers, bit capture, frame FSM and output stage
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], i2s_sck_i};
        ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0], i2s_ws_i};
        sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata_i};
        sck_dly_d  = sck_sync_q[SYNC_STAGES-1];
        rise_d     = sck_sync_q[SYNC_STAGES-1] & ~sck_dly_q;
        ws_smp_d   = ws_sync_q[SYNC_STAGES-1];
        sd_smp_d   = sd_sync_q[SYNC_STAGES-1];
        ws_last_d  = ws_last_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        left_d     = left_q;
        state_d    = state_q;
        frame_done = 1'b0;
        err_d      = 1'b0;
        ovf_d      = 1'b0;
        valid_d    = valid_q & ~outport.tready;
        data_d     = data_q;
        last_d     = last_q;
        pkt_cnt_d  = pkt_cnt_q;
        ws_chg     = rise_q & (ws_smp_q != ws_last_q);
        chan_full  = (bit_cnt_q == CNT_W'(SAMPLE_W));

        // The bit sampled with a WS change belongs to the old channel and is dropped
        if (rise_q) begin
            ws_last_d = ws_smp_q;
            if (ws_chg) begin
                bit_cnt_d = '0;
            end else if (bit_cnt_q < CNT_W'(SAMPLE_W)) begin
                shift_d   = {shift_q[SAMPLE_W-2:0], sd_smp_q};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        if (ws_chg) begin
            case (state_q)
                ST_ALIGN: begin
                    if (!ws_smp_q) state_d = ST_LEFT;
                end
                ST_LEFT: begin
                    if (chan_full) begin
                        left_d  = shift_q;
                        state_d = ST_RIGHT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ALIGN;
                    end
                end
                ST_RIGHT: begin
                    // A short right channel still leaves this edge as a valid left start
                    if (chan_full) frame_done = 1'b1;
                    else           err_d      = 1'b1;
                    state_d = ST_LEFT;
                end
                default: state_d = ST_ALIGN;
            endcase
        end

        // Load only into a free slot or one being drained this cycle
        if (frame_done) begin
            if (!valid_q || outport.tready) begin
                valid_d   = 1'b1;
                data_d    = {16'(left_q) << PAD_W, 16'(shift_q) << PAD_W};
                last_d    = (pkt_cnt_q == PKT_W'(FRAMES_PER_PKT - 1));
                pkt_cnt_d = last_d ? '0 : pkt_cnt_q + PKT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end

        strb_d = valid_d ? 4'hF : 4'h0;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q <= '0;
            ws_sync_q  <= '0;
            sd_sync_q  <= '0;
            sck_dly_q  <= 1'b0;
            rise_q     <= 1'b0;
            ws_smp_q   <= 1'b0;
            sd_smp_q   <= 1'b0;
            ws_last_q  <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            left_q     <= '0;
            state_q    <= ST_ALIGN;
            valid_q    <= 1'b0;
            data_q     <= '0;
            strb_q     <= '0;
            last_q     <= 1'b0;
            pkt_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            ws_sync_q  <= ws_sync_d;
            sd_sync_q  <= sd_sync_d;
            sck_dly_q  <= sck_dly_d;
            rise_q     <= rise_d;
            ws_smp_q   <= ws_smp_d;
            sd_smp_q   <= sd_smp_d;
            ws_last_q  <= ws_last_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            left_q     <= left_d;
            state_q    <= state_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            last_q     <= last_d;
            pkt_cnt_q  <= pkt_cnt_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    assign outport.tvalid = valid_q;
    assign outport.tdata  = data_q;
    assign outport.tstrb  = strb_q;
    assign outport.tdest  = TDEST;
    assign outport.tlast  = last_q;
    assign overflow_o     = ovf_q;
    assign frame_err_o    = err_q;

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Bench for audio_i2s_rx: two receivers (1 and 4 frames per packet) share one
// I2S stream; delivered beats and pulse counts are scored against a
// channel-level model of the I2S framing rules.
module tb_audio_i2s_rx;
    localparam int unsigned SW = 16;

    logic clk = 1'b0;
    logic rst, sck, ws, sd, tready;
    logic ovf1, err1, ovf4, err4;

    always #5 clk = ~clk;

    audio_i2s_rx_if if1();
    audio_i2s_rx_if if4();
    assign if1.tready = tready;
    assign if4.tready = tready;

    audio_i2s_rx #(.SAMPLE_W(SW), .SYNC_STAGES(2), .FRAMES_PER_PKT(1), .TDEST(4'hA)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sdata_i(sd),
        .outport(if1), .overflow_o(ovf1), .frame_err_o(err1));

    audio_i2s_rx #(.SAMPLE_W(SW), .SYNC_STAGES(2), .FRAMES_PER_PKT(4), .TDEST(4'h3)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sdata_i(sd),
        .outport(if4), .overflow_o(ovf4), .frame_err_o(err4));

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observed side: handshakes, pulse counts, strobe consistency
    logic [32:0] got1[$], got4[$], exp1[$], exp4[$];
    int n_ovf1 = 0, n_err1 = 0, n_ovf4 = 0, n_err4 = 0, strb_bad = 0;

    always @(negedge clk) begin
        if (if1.tvalid && tready) got1.push_back({if1.tlast, if1.tdata});
        if (if4.tvalid && tready) got4.push_back({if4.tlast, if4.tdata});
        if (ovf1) n_ovf1++;
        if (err1) n_err1++;
        if (ovf4) n_ovf4++;
        if (err4) n_err4++;
        if (if1.tstrb !== (if1.tvalid ? 4'hF : 4'h0)) strb_bad++;
        if (if4.tstrb !== (if4.tvalid ? 4'hF : 4'h0)) strb_bad++;
    end

    // Channel-level reference model
    bit          m_last_ws, m_in_left, m_have_left, m_held;
    logic [15:0] m_left;
    int          m_pkt4, e_ovf = 0, e_err = 0;
    int          c_bits;
    logic [15:0] c_word;

    task automatic model_reset();
        m_last_ws = 0; m_in_left = 0; m_have_left = 0; m_held = 0;
        m_pkt4 = 0; c_bits = 0; c_word = '0;
    endtask

    task automatic model_frame(input logic [31:0] data, input bit tr_at, input bit stays);
        if (m_held && !tr_at) begin
            e_ovf++;
        end else begin
            exp1.push_back({1'b1, data});
            exp4.push_back({m_pkt4 == 3, data});
            m_pkt4 = (m_pkt4 + 1) % 4;
            m_held = !stays;
        end
    endtask

    // Called when a channel with a new WS value begins; closes the previous channel
    task automatic model_edge(input bit new_ws, input bit tr_at, input bit stays);
        bit full;
        full = (c_bits >= SW);
        if (new_ws) begin
            if (m_in_left) begin
                if (full) begin m_left = c_word; m_have_left = 1; end
                else e_err++;
            end
            m_in_left = 0;
        end else begin
            if (m_have_left) begin
                if (full) model_frame({m_left, c_word}, tr_at, stays);
                else e_err++;
            end
            m_have_left = 0;
            m_in_left = 1;
        end
        m_last_ws = new_ws;
    endtask

    task automatic set_ready(input bit v);
        tready = v;
        if (v) m_held = 0;
    endtask

    // One SCK period: low phase then high phase, 4 clk each.
    // mode 1 pulses tready on the frame-load edge, mode 2 checks output latency.
    task automatic send_bit(input bit w, input bit d, input int mode);
        sck = 1'b0; ws = w; sd = d;
        repeat (4) begin @(posedge clk); #1; end
        sck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (mode == 1 && i == 2) tready = 1'b1;
            if (mode == 1 && i == 3) tready = 1'b0;
            if (mode == 2 && i == 2) check_eq("lat_before", 64'(if1.tvalid), 64'd0);
            if (mode == 2 && i == 3) check_eq("lat_at", 64'(if1.tvalid), 64'd1);
        end
    endtask

    // Channel of n SCK periods: first carries the old channel's LSB, then word MSB first
    task automatic send_chan(input bit w, input int n, input logic [15:0] word, input int mode);
        if (w != m_last_ws) begin
            if (mode == 1) model_edge(w, 1'b1, 1'b0);
            else           model_edge(w, tready, tready);
        end
        send_bit(w, 1'($urandom), mode);
        for (int k = 1; k < n; k++)
            send_bit(w, (k <= 16) ? word[16-k] : 1'($urandom), 0);
        c_bits = n - 1;
        c_word = word;
    endtask

    logic [15:0] l5[6], r5[5];
    int ovf_before;

    initial begin
        rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; tready = 1'b1;
        model_reset();
        @(posedge clk); #1;

        // T1: reset with SCK toggling
        send_bit(1'b1, 1'b0, 0);
        check_eq("rst_tvalid", 64'(if1.tvalid), 64'd0);
        check_eq("rst_tdata", 64'(if1.tdata), 64'd0);
        check_eq("rst_tstrb", 64'(if1.tstrb), 64'd0);
        check_eq("rst_tlast", 64'(if1.tlast), 64'd0);
        check_eq("rst_pulses", 64'({ovf1, err1, ovf4, err4}), 64'd0);
        check_eq("rst_tdest1", 64'(if1.tdest), 64'hA);
        check_eq("rst_tdest4", 64'(if4.tdest), 64'h3);
        rst = 1'b0;
        model_reset();
        send_chan(1'b1, 32, 16'($urandom), 0);
        send_chan(1'b0, 32, 16'hA5C3, 0);
        send_chan(1'b1, 32, 16'h3C5A, 0);
        check_eq("no_beat_before_frame", 64'(got1.size()), 64'd0);

        // T2: completion on the next left start, with latency check
        send_chan(1'b0, 32, 16'h1111, 2);
        check_eq("t2_beats", 64'(got1.size()), 64'd1);
        check_eq("t2_beat", 64'(got1[0]), {31'd0, 1'b1, 32'hA5C33C5A});
        send_chan(1'b1, 32, 16'h0000, 0);

        // T3: backpressure across two frames
        set_ready(1'b0);
        send_chan(1'b0, 32, 16'h2222, 0);
        send_chan(1'b1, 32, 16'h0001, 0);
        send_chan(1'b0, 11, 16'($urandom), 0);
        check_eq("t3_held_valid", 64'(if1.tvalid), 64'd1);
        check_eq("t3_held_data", 64'(if1.tdata), 64'h11110000);
        check_eq("t3_ovf", 64'(n_ovf1), 64'd1);
        set_ready(1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check_eq("t3_beats", 64'(got1.size()), 64'd2);
        check_eq("t3_beat", 64'(got1[1]), {31'd0, 1'b1, 32'h11110000});

        // T4: short left channel, then a good frame
        send_chan(1'b1, 32, 16'($urandom), 0);
        check_eq("t4_err", 64'(n_err1), 64'd1);
        check_eq("t4_no_beat", 64'(got1.size()), 64'd2);
        send_chan(1'b0, 32, 16'h1234, 0);
        send_chan(1'b1, 32, 16'h5678, 0);

        // T5: five full frames; the first left start completes 12345678
        for (int i = 0; i < 6; i++) l5[i] = 16'($urandom);
        for (int i = 0; i < 5; i++) r5[i] = 16'($urandom);
        send_chan(1'b0, 32, l5[0], 0);
        check_eq("t4_beat", 64'(got1[2]), {31'd0, 1'b1, 32'h12345678});
        for (int i = 0; i < 5; i++) begin
            send_chan(1'b1, 32, r5[i], 0);
            send_chan(1'b0, 32, l5[i+1], 0);
        end

        // Random channel lengths and sink readiness
        for (int i = 0; i < 12; i++) begin
            send_chan(1'b1, $urandom_range(33, 8), 16'($urandom), 0);
            set_ready(($urandom % 3) != 0);
            send_chan(1'b0, $urandom_range(33, 8), 16'($urandom), 0);
        end
        set_ready(1'b1);

        // T6: reset inside a right channel, then backpressured frames with a ready pulse
        send_chan(1'b1, 32, 16'($urandom), 0);
        send_chan(1'b0, 32, 16'($urandom), 0);
        send_chan(1'b1, 12, 16'($urandom), 0);
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_reset();
        ovf_before = n_ovf1;
        send_chan(1'b1, 20, 16'($urandom), 0);
        send_chan(1'b0, 32, 16'h0BAD, 0);
        send_chan(1'b1, 32, 16'hF00D, 0);
        set_ready(1'b0);
        send_chan(1'b0, 32, 16'hCAFE, 0);
        send_chan(1'b1, 32, 16'hBEEF, 0);
        send_chan(1'b0, 32, 16'($urandom), 1);
        check_eq("t6_no_ovf", 64'(n_ovf1), 64'(ovf_before));
        check_eq("t6_held", 64'(if1.tdata), 64'hCAFEBEEF);
        set_ready(1'b1);
        repeat (4) begin @(posedge clk); #1; end

        // Scoreboard
        check_eq("ovf1_count", 64'(n_ovf1), 64'(e_ovf));
        check_eq("err1_count", 64'(n_err1), 64'(e_err));
        check_eq("ovf4_count", 64'(n_ovf4), 64'(e_ovf));
        check_eq("err4_count", 64'(n_err4), 64'(e_err));
        check_eq("strb_bad", 64'(strb_bad), 64'd0);
        check_eq("beats1", 64'(got1.size()), 64'(exp1.size()));
        check_eq("beats4", 64'(got4.size()), 64'(exp4.size()));
        for (int i = 0; i < exp1.size(); i++)
            check_eq($sformatf("beat1_%0d", i), 64'(got1[i]), 64'(exp1[i]));
        for (int i = 0; i < exp4.size(); i++)
            check_eq($sformatf("beat4_%0d", i), 64'(got4[i]), 64'(exp4[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
